// File: rtl/updown_bcd_source.sv
// Button-driven up/down/clear counter feeding the BCD display wrapper.
// Raw buttons are synchronised, debounced and edge-detected before they touch the count.
module updown_bcd_source #(
  parameter int NBITS     = 7,
  parameter int MAXVAL    = 99,
  parameter int DB_CYCLES = 50000,
  parameter int WRAP      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_clr,
  output logic [NBITS-1:0] value,
  output logic             changed
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [NBITS-1:0] MAX_V    = NBITS'(MAXVAL);

  // Button index: 0 = up, 1 = down, 2 = clear.
  logic [2:0]         s1_q, s2_q;
  logic [2:0]         lvl_q, lvl_d;
  logic [2:0]         prev_q;
  logic [2:0][CW-1:0] cnt_q, cnt_d;
  logic [2:0]         press;

  logic [NBITS-1:0]   value_q, value_d;
  logic               changed_q, changed_d;

  // Debounce: the level follows s2 only after DB_CYCLES consecutive differing samples.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (s2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          lvl_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press = lvl_q & ~prev_q;

  always_comb begin
    value_d   = value_q;
    changed_d = 1'b0;
    if (press[2]) begin
      value_d   = '0;
      changed_d = 1'b1;
    end else if (press[0] && press[1]) begin
      changed_d = 1'b0;
    end else if (press[0]) begin
      if (value_q < MAX_V) begin
        value_d   = value_q + 1'b1;
        changed_d = 1'b1;
      end else if (WRAP != 0) begin
        value_d   = '0;
        changed_d = 1'b1;
      end
    end else if (press[1]) begin
      if (value_q != '0) begin
        value_d   = value_q - 1'b1;
        changed_d = 1'b1;
      end else if (WRAP != 0) begin
        value_d   = MAX_V;
        changed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      lvl_q     <= '0;
      prev_q    <= '0;
      cnt_q     <= '0;
      value_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      s1_q      <= {btn_clr, btn_down, btn_up};
      s2_q      <= s1_q;
      lvl_q     <= lvl_d;
      prev_q    <= lvl_q;
      cnt_q     <= cnt_d;
      value_q   <= value_d;
      changed_q <= changed_d;
    end
  end

  assign value   = value_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_updown_bcd_source.sv
// Bench for updown_bcd_source: wrapping and saturating instances share the buttons;
// expected updates are queued at stimulus time and popped when the DUT strobes changed.
module tb_updown_bcd_source;

  localparam int NB   = 7;
  localparam int MAXV = 99;
  localparam int DB   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_up, btn_down, btn_clr;
  logic [NB-1:0] val_w, val_s;
  logic          chg_w, chg_s;

  updown_bcd_source #(.NBITS(NB), .MAXVAL(MAXV), .DB_CYCLES(DB), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
    .value(val_w), .changed(chg_w)
  );

  updown_bcd_source #(.NBITS(NB), .MAXVAL(MAXV), .DB_CYCLES(DB), .WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
    .value(val_s), .changed(chg_s)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_on   = 1'b0;
  bit prev_w   = 1'b0;
  bit prev_s   = 1'b0;
  int mv_w     = 0;
  int mv_s     = 0;
  logic [NB-1:0] exp_w_q[$];
  logic [NB-1:0] exp_s_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the count.
  task automatic step(input int v, input bit u, input bit d, input bit c, input bit wrap,
                      output int nv, output bit chg);
    nv  = v;
    chg = 1'b0;
    if (c) begin
      nv  = 0;
      chg = 1'b1;
    end else if (u && !d) begin
      nv  = wrap ? (v + 1) % (MAXV + 1) : ((v + 1 > MAXV) ? MAXV : v + 1);
      chg = (nv != v);
    end else if (d && !u) begin
      nv  = wrap ? (v + MAXV) % (MAXV + 1) : ((v == 0) ? 0 : v - 1);
      chg = (nv != v);
    end
  endtask

  task automatic apply_model(input bit u, input bit d, input bit c);
    int nv;
    bit chg;
    step(mv_w, u, d, c, 1'b1, nv, chg);
    if (chg) exp_w_q.push_back(NB'(nv));
    mv_w = nv;
    step(mv_s, u, d, c, 1'b0, nv, chg);
    if (chg) exp_s_q.push_back(NB'(nv));
    mv_s = nv;
  endtask

  // Driver tasks
  task automatic press(input bit u, input bit d, input bit c, input int hold, input int gap);
    @(posedge clk); #1;
    btn_up = u; btn_down = d; btn_clr = c;
    apply_model(u, d, c);
    repeat (hold) @(posedge clk);
    #1;
    btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic glitch(input int which, input int len);
    @(posedge clk); #1;
    case (which)
      0: btn_up = 1'b1;
      1: btn_down = 1'b1;
      default: btn_clr = 1'b1;
    endcase
    repeat (len) @(posedge clk);
    #1;
    btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
    repeat (DB + 3) @(posedge clk);
  endtask

  // Called just after inputs are set; the next rising edge is edge 0.
  task automatic expect_timed(input string tag, input int ow, input int os,
                              input int nw, input int ns, input bit cw, input bit cs);
    repeat (DB + 2) @(posedge clk);
    @(negedge clk);
    check({tag, "_w_before"}, val_w, ow);
    check({tag, "_s_before"}, val_s, os);
    check({tag, "_chg_before"}, {chg_w, chg_s}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_w_after"}, val_w, nw);
    check({tag, "_s_after"}, val_s, ns);
    check({tag, "_chg_after"}, {chg_w, chg_s}, {cw, cs});
    @(posedge clk);
    @(negedge clk);
    check({tag, "_chg_drop"}, {chg_w, chg_s}, 2'b00);
  endtask

  task automatic check_model(input string tag);
    @(negedge clk);
    check({tag, "_w"}, val_w, mv_w);
    check({tag, "_s"}, val_s, mv_s);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_on && rst) begin
      n_checks++;
      if (val_w > NB'(MAXV) || val_s > NB'(MAXV)) begin
        n_fail++;
        $display("FAIL range: wrap %0d sat %0d limit %0d", val_w, val_s, MAXV);
      end
      if (chg_w) begin
        check("wrap_strobe_gap", prev_w, 0);
        if (exp_w_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL wrap_unexpected_change: value %0d with none expected", val_w);
        end else begin
          check("wrap_value", val_w, exp_w_q.pop_front());
        end
      end
      if (chg_s) begin
        check("sat_strobe_gap", prev_s, 0);
        if (exp_s_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sat_unexpected_change: value %0d with none expected", val_s);
        end else begin
          check("sat_value", val_s, exp_s_q.pop_front());
        end
      end
    end
    prev_w = rst && chg_w;
    prev_s = rst && chg_s;
  end

  initial begin
    int ow, os;
    rst = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_value", {val_w, val_s}, 14'd0);
    check("reset_changed", {chg_w, chg_s}, 2'b00);
    rst = 1'b1;
    mon_on = 1'b1;
    repeat (2) @(posedge clk);

    // Held press counts exactly once, at edge DB+2.
    @(posedge clk); #1;
    btn_up = 1'b1;
    apply_model(1'b1, 1'b0, 1'b0);
    expect_timed("hold", 0, 0, 1, 1, 1'b1, 1'b1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    check("hold_no_repeat", {val_w, val_s}, {7'd1, 7'd1});
    btn_up = 1'b0;
    repeat (DB + 3) @(posedge clk);

    // Bouncing contact followed by a stable press.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      btn_up = (i % 2 == 0);
    end
    @(posedge clk); #1;
    btn_up = 1'b1;
    apply_model(1'b1, 1'b0, 1'b0);
    expect_timed("bounce", 1, 1, 2, 2, 1'b1, 1'b1);
    #1 btn_up = 1'b0;
    repeat (DB + 3) @(posedge clk);

    // Limits: wrap versus saturate at 0 and MAXVAL.
    press(1'b0, 1'b0, 1'b1, DB + 4, DB + 4);
    check_model("clear");
    press(1'b0, 1'b1, 1'b0, DB + 4, DB + 4);
    check_model("down_at_zero");
    check("down_at_zero_const", {val_w, val_s}, {7'd99, 7'd0});
    for (int i = 0; i < MAXV + 1; i++) press(1'b1, 1'b0, 1'b0, DB + 2, DB + 2);
    check_model("climb");
    check("sat_at_max_const", val_s, 99);
    press(1'b1, 1'b0, 1'b0, DB + 4, DB + 4);
    check_model("up_at_max");
    check("wrap_to_zero_const", {val_w, val_s}, {7'd0, 7'd99});
    press(1'b0, 1'b1, 1'b0, DB + 4, DB + 4);
    check_model("down_wrap");

    // Simultaneous presses.
    press(1'b1, 1'b1, 1'b0, DB + 4, DB + 4);
    check_model("up_down_same");
    press(1'b1, 1'b1, 1'b1, DB + 4, DB + 4);
    check_model("clr_wins");
    press(1'b0, 1'b0, 1'b1, DB + 4, DB + 4);
    check_model("clr_at_zero");

    // Reset in the middle of a debounce, button held through it.
    for (int i = 0; i < 37; i++) press(1'b1, 1'b0, 1'b0, DB + 2, DB + 2);
    check_model("at_37");
    @(posedge clk); #1;
    btn_up = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_value", {val_w, val_s}, 14'd0);
    check("mid_reset_changed", {chg_w, chg_s}, 2'b00);
    mv_w = 0; mv_s = 0;
    #1 rst = 1'b1;
    apply_model(1'b1, 1'b0, 1'b0);
    expect_timed("post_reset", 0, 0, 1, 1, 1'b1, 1'b1);
    #1 btn_up = 1'b0;
    repeat (DB + 3) @(posedge clk);

    // Random press / glitch sequence.
    for (int e = 0; e < 500; e++) begin
      if ($urandom_range(0, 4) == 0) begin
        glitch($urandom_range(0, 2), $urandom_range(1, DB - 1));
      end else begin
        bit u, d, c;
        u = $urandom_range(0, 1);
        d = $urandom_range(0, 1);
        c = ($urandom_range(0, 7) == 0);
        if (!u && !d && !c) u = 1'b1;
        press(u, d, c, $urandom_range(DB, DB + 8), $urandom_range(DB + 1, DB + 8));
      end
    end
    repeat (20) @(posedge clk);
    check_model("random_final");
    check("wrap_pending", exp_w_q.size(), 0);
    check("sat_pending", exp_s_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_bcd_source.md
Name: updown_bcd_source

Overview:
- Upstream stage that generates the binary value fed to the display wrapper's `binary_in` input.
- Takes three raw pushbuttons from the board: up, down and clear.
- Each button is synchronised, debounced and edge-detected.
- The result drives a wrapping or saturating up/down counter limited to MAXVAL, which is the largest value the display digits can show.
- A one-cycle `changed` strobe marks every value update for downstream consumers.

Parameters:
- NBITS, 7, width of `value`; MAXVAL must fit in NBITS bits.
- MAXVAL, 99, largest count value (10^NDIGITS-1 for the display).
- DB_CYCLES, 50000, consecutive stable samples required before the debounced level changes; must be ≥2.
- WRAP, 1, 1 = wrap at the limits, 0 = saturate at the limits.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- btn_up  input  1  raw button, active-high, asynchronous to clk.
- btn_down  input  1  raw button, active-high, asynchronous to clk.
- btn_clr  input  1  raw button, active-high, asynchronous to clk.
- value  output  NBITS  current count, registered.
- changed  output  1  one-cycle pulse, high in the cycle after `value` was written.

Behaviour:
- **Reset** (rst=0 at a clk edge):
  - value=0, changed=0.
  - All synchroniser flops, debounced levels, previous-level flops and debounce counters = 0.
  - Reset has priority over all other activity; a debounce in progress is discarded.
- **Synchroniser**: two flops per button (s1, s2). No other logic reads the raw inputs.
- **Debounce** (one per button, counter width ceil(log2(DB_CYCLES)) bits):
  - If s2 == db_level, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter reaches DB_CYCLES-1 while s2 still differs, db_level takes s2 and the counter clears on that same edge.
  - Any bounce back to db_level before then restarts the count.
- **Edge detect**:
  - A press event is db_level & ~db_prev, where db_prev is db_level registered.
  - Release events are ignored.
- **Timing**:
  - Edge 0 is the first edge that samples a raw button high, held stable.
  - db_level rises at edge DB_CYCLES+1.
  - value updates at edge DB_CYCLES+2.
  - changed is high for exactly the cycle following that edge.
- **Counter update priority** (per cycle, from press events):
  1. clr: value←0. If value was already 0, changed still pulses.
  2. up and down pressed in the same cycle: no change, changed=0.
  3. up only:
     - value<MAXVAL: value+1.
     - value==MAXVAL: 0 if WRAP=1, else hold with changed=0.
  4. down only:
     - value>0: value-1.
     - value==0: MAXVAL if WRAP=1, else hold with changed=0.
- **Holding**: a held button counts once; there is no auto-repeat. Release plus a new debounced press is needed to count again.
- **Button held through reset**: after rst releases, the button is re-debounced from zero. It produces one press event DB_CYCLES+2 edges after the first post-reset sampling edge.
- **Range**: value is never > MAXVAL. Arithmetic is NBITS wide, with no overflow under the MAXVAL constraint.
- **Changed strobe**: changed is never high for two consecutive cycles. Press events from one button are at least DB_CYCLES apart.

Test Plan:
1. DB_CYCLES=4, WRAP=1, reset, then btn_up held high → value=1 at edge 6 after the first high sample; changed high for 1 cycle; still 1 after 100 held cycles.
2. btn_up bouncing 1,0,1,0 every cycle for 10 cycles, then stable high → exactly one increment, occurring 6 edges after the final stable rising sample.
3. value=99, one up press → value=0, changed pulses. Then one down press → value=99. Repeat with WRAP=0 → value holds at 99 / 0 and changed stays 0.
4. btn_up and btn_down rising on the same cycle (debounced together) → value unchanged, changed=0. Add btn_clr in the same cycle with value=42 → value=0, changed=1.
5. value=37, then rst=0 for 1 cycle during a debounce count → value=0 at the following edge. A button still held after reset produces +1 exactly 6 edges after the first post-reset sampling edge.
6. Random press/release sequence of 500 events against a reference model → value matches, 0≤value≤MAXVAL, changed never asserted on consecutive cycles.
